// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin two-port arbiter and byte-beat sequencer for a
//             byte-wide, synchronous-read data memory. Byte/half/word
//             accesses run as big-endian byte beats.
//  Options  : DMEM_ARB_ALIGN_CHECK_EN - reject misaligned half/word
//             accesses with a one-cycle error ack.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [1:0]        size0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              ack0,
  output logic [31:0]       rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [1:0]        size1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              ack1,
  output logic [31:0]       rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              we_q, we_d;
  logic [1:0]        last_beat_q, last_beat_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       result_q, result_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              w_sel;
  logic              w_we;
  logic [1:0]        w_size;
  logic [1:0]        w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [31:0]       w_aligned;
  logic              w_reject;
  logic [31:0]       w_shifted;

  // Pick the winning port (round-robin on contest) and left-justify its data
  always_comb begin
    w_sel   = (req0 && req1) ? ~last_gnt_q : req1;
    w_we    = w_sel ? we1    : we0;
    w_size  = w_sel ? size1  : size0;
    w_addr  = w_sel ? addr1  : addr0;
    w_wdata = w_sel ? wdata1 : wdata0;
    case (w_size)
      2'b00:   begin w_last = 2'd0; w_aligned = {w_wdata[7:0], 24'h0};  end
      2'b01:   begin w_last = 2'd1; w_aligned = {w_wdata[15:0], 16'h0}; end
      default: begin w_last = 2'd3; w_aligned = w_wdata;                end
    endcase
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign w_reject = ((w_size == 2'b01) && w_addr[0]) ||
                    (w_size[1] && (w_addr[1:0] != 2'b00));
`else
  assign w_reject = 1'b0;
`endif

  // Load result with the byte returned for the previous beat appended
  assign w_shifted = {result_q[23:0], mem_rdata};

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    we_d        = we_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    wdata_d     = wdata_q;
    result_d    = result_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = 8'h00;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d       = w_sel;
          we_d        = w_we;
          last_beat_d = w_last;
          beat_d      = 2'd0;
          result_d    = 32'h0;
          if (w_reject) begin
            // Misaligned: answer immediately, no memory traffic
            state_d = ACK;
            if (w_sel) begin
              ack1_d = 1'b1; err1_d = 1'b1; rdata1_d = 32'h0;
            end else begin
              ack0_d = 1'b1; err0_d = 1'b1; rdata0_d = 32'h0;
            end
          end else begin
            // Present beat 0 in the very next cycle
            state_d     = ACCESS;
            mem_addr_d  = w_addr;
            mem_we_d    = w_we;
            mem_wdata_d = w_we ? w_aligned[31:24] : 8'h00;
            wdata_d     = w_aligned << 8;
          end
        end
      end

      ACCESS: begin
        if (!we_q && (beat_q != 2'd0)) begin
          result_d = w_shifted;
        end
        if (beat_q == last_beat_q) begin
          state_d = CAPTURE;
        end else begin
          beat_d      = beat_q + 2'd1;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_we_d    = we_q;
          mem_wdata_d = we_q ? wdata_q[31:24] : 8'h00;
          wdata_d     = wdata_q << 8;
        end
      end

      CAPTURE: begin
        state_d = ACK;
        if (gnt_q) begin
          ack1_d = 1'b1;
          err1_d = 1'b0;
          if (!we_q) rdata1_d = w_shifted;
        end else begin
          ack0_d = 1'b1;
          err0_d = 1'b0;
          if (!we_q) rdata0_d = w_shifted;
        end
      end

      ACK: begin
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      we_q        <= 1'b0;
      last_beat_q <= 2'd0;
      beat_q      <= 2'd0;
      wdata_q     <= 32'h0;
      result_q    <= 32'h0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      we_q        <= we_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a
//             byte-wide synchronous-read memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0]        size0 = 2'b00, size1 = 2'b00;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]       wdata0 = 32'h0, wdata1 = 32'h0;
  logic              ack0, ack1, err0, err1;
  logic [31:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [7:0]        bd_data = 8'h00;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory: write and synchronous read, plus a bench back-door write
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one transaction from an idle negedge; returns latency (-1 on timeout)
  task automatic run_txn(input int port, input logic we, input logic [1:0] sz,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int other_acks, output int we_pulses);
    lat = -1; rd = 32'h0; er = 1'b0; other_acks = 0; we_pulses = 0;
    if (port == 0) begin req0 = 1'b1; we0 = we; size0 = sz; addr0 = a; wdata0 = wd; end
    else           begin req1 = 1'b1; we1 = we; size1 = sz; addr1 = a; wdata1 = wd; end
    for (int c = 1; c <= 50 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_we) we_pulses++;
      if ((port == 0 && ack1) || (port == 1 && ack0)) other_acks++;
      if (port == 0 && ack0) begin lat = c; rd = rdata0; er = err0; end
      if (port == 1 && ack1) begin lat = c; rd = rdata1; er = err1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {ack0, ack1, err0, err1});
    end
    checks++;
    if ({rdata0, rdata1} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h_%h exp=0", rdata0, rdata1);
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== 23'h0) begin
      failures++; $display("FAIL reset_mem got we=%b addr=%h wd=%h exp=0", mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int lat, oth, wep; logic [31:0] rd; logic er;
    run_txn(0, 1'b1, 2'b10, 14'h0010, 32'h11223344, lat, rd, er, oth, wep);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL store_latency got=%0d exp=6", lat); end
    checks++;
    if ({mem[14'h10], mem[14'h11], mem[14'h12], mem[14'h13]} !== 32'h11223344) begin
      failures++; $display("FAIL store_bytes got=%h%h%h%h exp=11223344",
                           mem[14'h10], mem[14'h11], mem[14'h12], mem[14'h13]);
    end
    checks++;
    if (wep !== 4 || oth !== 0 || rd !== 32'h0) begin
      failures++; $display("FAIL store_side got we_pulses=%0d other=%0d rdata=%h exp 4/0/0", wep, oth, rd);
    end
    run_txn(0, 1'b0, 2'b10, 14'h0010, 32'h0, lat, rd, er, oth, wep);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL load_word_latency got=%0d exp=6", lat); end
    checks++;
    if (rd !== 32'h11223344) begin failures++; $display("FAIL load_word_data got=%h exp=11223344", rd); end
    checks++;
    if (wep !== 0 || er !== 1'b0) begin
      failures++; $display("FAIL load_word_side got we_pulses=%0d err=%b exp 0/0", wep, er);
    end
  endtask

  task automatic test_port1_loads();
    int lat, oth, wep; logic [31:0] rd; logic er;
    run_txn(1, 1'b0, 2'b00, 14'h0012, 32'h0, lat, rd, er, oth, wep);
    checks++;
    if (lat !== 3 || rd !== 32'h00000033) begin
      failures++; $display("FAIL load_byte got lat=%0d rdata=%h exp 3/00000033", lat, rd);
    end
    checks++;
    if (oth !== 0) begin failures++; $display("FAIL load_byte_other_ack got=%0d exp=0", oth); end
    run_txn(1, 1'b0, 2'b01, 14'h0012, 32'h0, lat, rd, er, oth, wep);
    checks++;
    if (lat !== 4 || rd !== 32'h00003344) begin
      failures++; $display("FAIL load_half got lat=%0d rdata=%h exp 4/00003344", lat, rd);
    end
    checks++;
    if (rdata0 !== 32'h11223344) begin
      failures++; $display("FAIL load_half_port0_held got=%h exp=11223344", rdata0);
    end
  endtask

  task automatic test_back_to_back();
    int ackp[4]; int ackc[4]; logic [31:0] r0[4]; logic [31:0] r1[4];
    int n_ack = 0;
    int exp_p[4]  = '{0, 1, 0, 1};
    logic [31:0] exp_r0[4] = '{32'h11, 32'h11, 32'h11, 32'h11};
    logic [31:0] exp_r1[4] = '{32'h3344, 32'h44, 32'h44, 32'h44};
    for (int i = 0; i < 4; i++) begin ackp[i] = -1; ackc[i] = -1; r0[i] = 32'hX; r1[i] = 32'hX; end
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b00; addr0 = 14'h0010;
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b00; addr1 = 14'h0013;
    for (int c = 1; c <= 60 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ackp[n_ack] = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        ackc[n_ack] = c;
        r0[n_ack] = rdata0;
        r1[n_ack] = rdata1;
        n_ack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ackp[i] !== exp_p[i] || ackc[i] !== 3 + 4 * i) begin
        failures++; $display("FAIL rr_grant%0d got port=%0d cyc=%0d exp port=%0d cyc=%0d",
                             i, ackp[i], ackc[i], exp_p[i], 3 + 4 * i);
      end
      checks++;
      if (r0[i] !== exp_r0[i] || r1[i] !== exp_r1[i]) begin
        failures++; $display("FAIL rr_rdata%0d got=%h/%h exp=%h/%h", i, r0[i], r1[i], exp_r0[i], exp_r1[i]);
      end
    end
  endtask

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  task automatic test_align();
    int lat, oth, wep; logic [31:0] rd; logic er;
    run_txn(0, 1'b0, 2'b10, 14'h0011, 32'h0, lat, rd, er, oth, wep);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL align_reject got lat=%0d err=%b rdata=%h exp 1/1/0", lat, er, rd);
    end
    checks++;
    if (wep !== 0) begin failures++; $display("FAIL align_no_write got=%0d exp=0", wep); end
    run_txn(0, 1'b0, 2'b00, 14'h0011, 32'h0, lat, rd, er, oth, wep);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h22) begin
      failures++; $display("FAIL align_ok got lat=%0d err=%b rdata=%h exp 3/0/22", lat, er, rd);
    end
  endtask
`else
  task automatic test_wrap();
    int lat, oth, wep; logic [31:0] rd; logic er;
    run_txn(1, 1'b1, 2'b10, 14'h3FFE, 32'hA1B2C3D4, lat, rd, er, oth, wep);
    checks++;
    if (lat !== 6 || er !== 1'b0) begin
      failures++; $display("FAIL wrap_latency got lat=%0d err=%b exp 6/0", lat, er);
    end
    checks++;
    if ({mem[14'h3FFE], mem[14'h3FFF], mem[14'h0000], mem[14'h0001]} !== 32'hA1B2C3D4) begin
      failures++; $display("FAIL wrap_bytes got=%h%h%h%h exp=a1b2c3d4",
                           mem[14'h3FFE], mem[14'h3FFF], mem[14'h0000], mem[14'h0001]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int late_acks = 0;
    for (int i = 0; i < 4; i++) bd_write(14'h0020 + 14'(i), 8'h00);
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 14'h0020; wdata0 = 32'h55667788;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 14'h0020 || mem_wdata !== 8'h55) begin
      failures++; $display("FAIL mid_beat0 got we=%b addr=%h wd=%h exp 1/0020/55", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1, mem_we, mem_addr, mem_wdata} !== 27'h0) begin
      failures++; $display("FAIL mid_reset_outputs got ack=%b%b we=%b addr=%h wd=%h exp 0",
                           ack0, ack1, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack0 || ack1 || mem_we) late_acks++;
    end
    checks++;
    if (late_acks !== 0) begin failures++; $display("FAIL mid_no_ack got=%0d exp=0", late_acks); end
    checks++;
    if ({mem[14'h20], mem[14'h21], mem[14'h22], mem[14'h23]} !== 32'h55660000) begin
      failures++; $display("FAIL mid_bytes got=%h%h%h%h exp=55660000",
                           mem[14'h20], mem[14'h21], mem[14'h22], mem[14'h23]);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_port1_loads();
    test_back_to_back();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    test_align();
`else
    test_wrap();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
